seq_serializer: RTL and testbench

- Parallel-in, serial-out bit source that feeds the 1101 sequence detector's single-bit input `i`.
- Accepts 16-bit words over a valid/ready handshake and shifts them out one bit per enabled cycle, LSB first.
- Supports gap-free back-to-back words, so the detector sees a continuous bit stream that can contain matches spanning word boundaries.

---
 rtl/seq_pkg.sv | 12 +
 rtl/ser_bit_counter.sv | 31 +++
 rtl/seq_serializer.sv | 107 ++++++++++
 tb/tb_seq_serializer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and sizing for the serial bit source that feeds the 1101 detector.
package seq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam int SEQ_WIDTH = 16;
    localparam int SER_CNT_W = $clog2(SEQ_WIDTH);

endpackage

// File: rtl/ser_bit_counter.sv
// Bit-position counter for the serializer: clears on a word load, advances on
// each shifted bit, and flags the last bit of the word.
module ser_bit_counter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_reg;

    // Saturates at the last bit; only a reload brings it back to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en && (cnt_reg != LAST)) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tc = (cnt_reg == LAST);

endmodule

// File: rtl/seq_serializer.sv
// Parallel-in, serial-out bit source: takes WIDTH-bit words over valid/ready
// and shifts them out one bit per shift_en strobe, with gap-free reloads.
module seq_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH     = SEQ_WIDTH,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int OUT_IDX = LSB_FIRST ? 0 : WIDTH - 1;

    ser_state_t       state_reg, state_next;
    logic [WIDTH-1:0] sreg_reg, sreg_next;
    logic [WIDTH-1:0] sreg_shifted;
    logic             word_done_reg, word_done_next;
    logic             tc;
    logic             cnt_clr, cnt_en;
    logic             last_shift;
    logic             load_fire;

    // Shift toward the output end so ser_out always reads a fixed position.
    if (LSB_FIRST) begin : g_lsb
        assign sreg_shifted = sreg_reg >> 1;
    end else begin : g_msb
        assign sreg_shifted = sreg_reg << 1;
    end

    ser_bit_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (tc)
    );

    assign last_shift = (state_reg == SHIFT) && tc && shift_en;
    assign load_ready = (state_reg == IDLE) || last_shift;
    assign load_fire  = load_valid && load_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            sreg_reg      <= '0;
            word_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sreg_reg      <= sreg_next;
            word_done_reg <= word_done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        sreg_next      = sreg_reg;
        word_done_next = 1'b0;
        cnt_clr        = load_fire;
        cnt_en         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (load_valid) begin
                    state_next = SHIFT;
                    sreg_next  = load_data;
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    if (tc) begin
                        word_done_next = 1'b1;
                        if (load_valid) begin
                            sreg_next = load_data;
                        end else begin
                            // Clearing the register is what forces ser_out low in IDLE.
                            state_next = IDLE;
                            sreg_next  = '0;
                        end
                    end else begin
                        cnt_en    = 1'b1;
                        sreg_next = sreg_shifted;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                sreg_next  = '0;
            end
        endcase
    end

    assign ser_out   = sreg_reg[OUT_IDX];
    assign ser_valid = (state_reg == SHIFT);
    assign busy      = ser_valid;
    assign word_done = word_done_reg;

endmodule

// File: tb/tb_seq_serializer.sv
// Scoreboard bench for seq_serializer: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against both DUT instances.
module tb_seq_serializer;
    import seq_pkg::*;

    localparam int W = SEQ_WIDTH;

    logic         tb_clk = 1'b0;
    logic         rst;
    logic         load_valid, load_valid_m;
    logic         shift_en;
    logic [W-1:0] load_data;
    logic         load_ready, ser_out, ser_valid, word_done, busy;
    logic         load_ready_m, ser_out_m, ser_valid_m, word_done_m, busy_m;

    always #5 tb_clk = ~tb_clk;

    seq_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut (
        .clk        (tb_clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .shift_en   (shift_en),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .word_done  (word_done),
        .busy       (busy)
    );

    seq_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
        .clk        (tb_clk),
        .rst        (rst),
        .load_valid (load_valid_m),
        .load_data  (load_data),
        .load_ready (load_ready_m),
        .shift_en   (shift_en),
        .ser_out    (ser_out_m),
        .ser_valid  (ser_valid_m),
        .word_done  (word_done_m),
        .busy       (busy_m)
    );

    typedef struct {
        int   cyc;
        bit   msb;
        int   tid;
        logic sv;
        logic so;
        logic lr;
        logic wd;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   n_vec    = 0;
    int   n_miscmp = 0;

    initial forever begin
        @(posedge tb_clk);
        cyc++;
    end

    // Monitor: every expectation due in this cycle is compared at the negedge.
    initial forever begin
        @(negedge tb_clk);
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            automatic exp_t       e = exp_q.pop_front();
            automatic logic [4:0] act;
            automatic logic [4:0] req;
            n_vec++;
            req = {e.sv, e.so, e.lr, e.wd, e.sv};
            if (e.msb)
                act = {ser_valid_m, ser_out_m, load_ready_m, word_done_m, busy_m};
            else
                act = {ser_valid, ser_out, load_ready, word_done, busy};
            if (e.cyc != cyc) begin
                n_miscmp++;
                $display("FAIL t%0d missed_cycle: expectation for cycle %0d checked at %0d", e.tid, e.cyc, cyc);
            end else if (act !== req) begin
                n_miscmp++;
                $display("FAIL t%0d cyc%0d %s sv/so/lr/wd/busy: got %b want %b",
                         e.tid, cyc, e.msb ? "msb" : "lsb", act, req);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push(input int c, input bit m, input int t,
                        input logic sv, input logic so, input logic lr, input logic wd);
        exp_t e;
        e.cyc = c; e.msb = m; e.tid = t;
        e.sv = sv; e.so = so; e.lr = lr; e.wd = wd;
        exp_q.push_back(e);
    endtask

    task automatic next();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic gap();
        repeat (3) next();
    endtask

    initial begin
        int           a;
        logic [W-1:0] w1, w2;

        rst = 1'b1; load_valid = 1'b0; load_valid_m = 1'b0;
        shift_en = 1'b0; load_data = '0;

        // Reset state on both instances.
        next();
        push(cyc, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        push(cyc, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        next();
        rst = 1'b0;
        push(cyc, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        push(cyc, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        gap();

        // T1: asynchronous reset mid-word at bit 5; no word_done afterwards.
        $display("t1: load FFFF, async reset at bit 5");
        a = cyc + 1;
        for (int i = 0; i < 5; i++) push(a + i, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 5; i < 8; i++) push(a + i, 1'b0, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        shift_en = 1'b1; load_data = 16'hFFFF; load_valid = 1'b1;
        next();
        load_valid = 1'b0;
        repeat (5) next();
        #2 rst = 1'b1;
        next();
        rst = 1'b0;
        gap();

        // T2: 000B -> 1,1,0,1 then twelve zeros, word_done right after bit 16.
        $display("t2: load 000B, shift_en high");
        w1 = 16'b0000_0000_0000_1011;
        a = cyc + 1;
        push(cyc, 1'b0, 2, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < W; i++) push(a + i, 1'b0, 2, 1'b1, w1[i], i == W - 1, 1'b0);
        push(a + W,     1'b0, 2, 1'b0, 1'b0, 1'b1, 1'b1);
        push(a + W + 1, 1'b0, 2, 1'b0, 1'b0, 1'b1, 1'b0);
        load_data = 16'h000B; load_valid = 1'b1;
        next();
        load_valid = 1'b0;
        repeat (W + 1) next();
        gap();

        // T3: FFFF then 0000 back to back with no bubble.
        $display("t3: back-to-back FFFF, 0000");
        a = cyc + 1;
        push(cyc, 1'b0, 3, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < W; i++) push(a + i, 1'b0, 3, 1'b1, 1'b1, i == W - 1, 1'b0);
        for (int i = 0; i < W; i++) push(a + W + i, 1'b0, 3, 1'b1, 1'b0, i == W - 1, i == 0);
        push(a + 2 * W,     1'b0, 3, 1'b0, 1'b0, 1'b1, 1'b1);
        push(a + 2 * W + 1, 1'b0, 3, 1'b0, 1'b0, 1'b1, 1'b0);
        load_data = 16'hFFFF; load_valid = 1'b1;
        next();
        load_data = 16'h0000;
        repeat (W) next();
        load_valid = 1'b0;
        repeat (W + 1) next();
        gap();

        // T4: 0005 with shift_en alternating; each bit is held two cycles.
        $display("t4: load 0005, shift_en toggling");
        w1 = 16'h0005;
        a = cyc + 1;
        push(cyc, 1'b0, 4, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < W; i++) begin
            push(a + 2 * i,     1'b0, 4, 1'b1, w1[i], 1'b0, 1'b0);
            push(a + 2 * i + 1, 1'b0, 4, 1'b1, w1[i], i == W - 1, 1'b0);
        end
        push(a + 2 * W, 1'b0, 4, 1'b0, 1'b0, 1'b1, 1'b1);
        load_data = w1; load_valid = 1'b1; shift_en = 1'b0;
        next();
        load_valid = 1'b0; shift_en = 1'b0;
        for (int k = 1; k < 2 * W; k++) begin
            next();
            shift_en = k[0];
        end
        next();
        shift_en = 1'b1;
        gap();

        // T5: MSB-first instance, D000 -> 1,1,0,1 then zeros.
        $display("t5: msb-first load D000");
        w1 = 16'b0000_0000_0000_1011;
        a = cyc + 1;
        push(cyc, 1'b1, 5, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < W; i++) push(a + i, 1'b1, 5, 1'b1, w1[i], i == W - 1, 1'b0);
        push(a + W, 1'b1, 5, 1'b0, 1'b0, 1'b1, 1'b1);
        load_data = 16'hD000; load_valid_m = 1'b1;
        next();
        load_valid_m = 1'b0;
        repeat (W) next();
        gap();

        // T6: a load offered at bit 7 is ignored until the last-bit window.
        $display("t6: early load_valid at bit 7");
        w1 = 16'h00F0;
        w2 = 16'hA5C3;
        a = cyc + 1;
        push(cyc, 1'b0, 6, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < W; i++) push(a + i, 1'b0, 6, 1'b1, w1[i], i == W - 1, 1'b0);
        for (int i = 0; i < W; i++) push(a + W + i, 1'b0, 6, 1'b1, w2[i], i == W - 1, i == 0);
        push(a + 2 * W, 1'b0, 6, 1'b0, 1'b0, 1'b1, 1'b1);
        load_data = w1; load_valid = 1'b1;
        next();
        load_valid = 1'b0;
        repeat (7) next();
        load_data = w2; load_valid = 1'b1;
        repeat (9) next();
        load_valid = 1'b0;
        repeat (W + 1) next();
        gap();

        for (int k = 0; k < 50 && exp_q.size() > 0; k++) next();
        if (exp_q.size() > 0) begin
            $display("FAIL drain: %0d expectations never checked, required 0", exp_q.size());
            n_miscmp += exp_q.size();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
